window_3x3_gen: RTL and testbench

Builds a 3x3 pixel neighbourhood from a 1 pixel/cycle raster stream and emits one window per accepted pixel once two full lines and two pixels of the current line are buffered. Sits directly upstream of the 3x3 median filter and drives its `in3x3_*` interface with the same window packing and frame markers. Uses two line buffers and a 3x3 shift register. Output frame is cropped to (W-2)x(H-2); no border synthesis.

---
 rtl/win_pkg.sv | 17 +
 rtl/line_buffer_ram.sv | 25 ++
 rtl/window_3x3_gen.sv | 236 +++++++++++++++++++++++
 tb/tb_window_3x3_gen.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/win_pkg.sv
// Shared types and constants for the 3x3 window generator: FSM states,
// window size and the (row, column) -> word offset mapping of the packed window.
package win_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  localparam int WIN_N = 3;

  // Word index of element (r,c); r=0 is the current line, c=0 the newest pixel.
  function automatic int word_idx(input int r, input int c);
    return WIN_N * r + c;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One line of pixel storage: single clock, asynchronous read, write on clock.
// A read and write to the same address in one cycle returns the old contents.
module line_buffer_ram #(
  parameter int  DATA_WIDTH = 8,
  parameter int  DEPTH      = 1024,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Builds a packed 3x3 neighbourhood from a 1 pixel/cycle raster stream, one
// window per accepted pixel once row>=2 and col>=2. Define WIN3X3_ERR_EN for err_flag.
module window_3x3_gen
  import win_pkg::*;
#(
  parameter int  DATA_WIDTH     = 8,
  parameter int  MAX_LINE_WIDTH = 1024,
  localparam int ADDR_WIDTH     = $clog2(MAX_LINE_WIDTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_val,
  output logic                                in_rdy,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_sof,
  input  logic                                in_eof,
  input  logic                                in_sol,
  input  logic                                in_eol,
  output logic                                in3x3_val,
  input  logic                                in3x3_rdy,
  output logic [WIN_N*WIN_N*DATA_WIDTH-1:0]   in3x3_data,
  output logic                                in3x3_sof,
  output logic                                in3x3_eof,
  output logic                                in3x3_sol,
  output logic                                in3x3_eol,
  output logic                                err_flag
);

  localparam logic [ADDR_WIDTH-1:0] COL_MAX       = ADDR_WIDTH'(MAX_LINE_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_FIRST_WIN = ADDR_WIDTH'(WIN_N - 1);
  localparam logic [1:0]            ROW_LAST      = 2'(WIN_N - 1);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] col_reg, col_next, col_eff;
  logic [1:0]            row_reg, row_next, row_eff;
  logic                  first_reg, first_next;

  logic                  accept;
  logic                  proc;
  logic                  emit;

  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;
  logic [DATA_WIDTH-1:0] col0_in  [WIN_N];
  logic [DATA_WIDTH-1:0] win_reg  [WIN_N][WIN_N-1];
  logic [DATA_WIDTH-1:0] win_next [WIN_N][WIN_N];
  logic [WIN_N*WIN_N*DATA_WIDTH-1:0] win_packed;

  assign in_rdy = !in3x3_val || in3x3_rdy;
  assign accept = in_val && in_rdy;

  // sof restarts the frame from any state; sol snaps the column back to 0.
  always_comb begin
    col_eff = col_reg;
    row_eff = row_reg;
    if (in_sof) begin
      col_eff = '0;
      row_eff = '0;
    end else if (in_sol) begin
      col_eff = '0;
    end
  end

  assign proc = accept && ((state_reg == ACTIVE) || in_sof);
  assign emit = proc && (row_eff == ROW_LAST) && (col_eff >= COL_FIRST_WIN);

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    first_next = first_reg;
    if (proc) begin
      state_next = ACTIVE;
      if (in_sof) begin
        first_next = 1'b1;
      end
      if (emit) begin
        first_next = 1'b0;
      end
      if (in_eol) begin
        col_next = '0;
        row_next = (row_eff == ROW_LAST) ? ROW_LAST : row_eff + 2'd1;
      end else begin
        col_next = (col_eff == COL_MAX) ? COL_MAX : col_eff + ADDR_WIDTH'(1);
      end
      if (in_eof) begin
        state_next = WAIT_SOF;
        col_next   = '0;
        row_next   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= WAIT_SOF;
      col_reg   <= '0;
      row_reg   <= '0;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      first_reg <= first_next;
    end
  end

  // LB0 holds the previous line, LB1 the line before it; LB0's old word moves down.
  line_buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_LINE_WIDTH)
  ) u_lb0 (
    .clk   (clk),
    .we    (proc),
    .addr  (col_eff),
    .wdata (in_data),
    .rdata (lb0_rd)
  );

  line_buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_LINE_WIDTH)
  ) u_lb1 (
    .clk   (clk),
    .we    (proc),
    .addr  (col_eff),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  assign col0_in[0] = in_data;
  assign col0_in[1] = lb0_rd;
  assign col0_in[2] = lb1_rd;

  // win_next is the window as it stands after this accept's shift.
  generate
    for (genvar gi = 0; gi < WIN_N; gi++) begin : g_row
      for (genvar gc = 0; gc < WIN_N; gc++) begin : g_col
        localparam int OFS = word_idx(gi, gc) * DATA_WIDTH;
        if (gc == 0) begin : g_new
          assign win_next[gi][gc] = col0_in[gi];
        end else begin : g_shift
          assign win_next[gi][gc] = in_sof ? '0 : win_reg[gi][gc-1];
        end
        assign win_packed[OFS +: DATA_WIDTH] = win_next[gi][gc];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int c = 0; c < WIN_N - 1; c++) begin
            win_reg[gi][c] <= '0;
          end
        end else if (proc) begin
          for (int c = 0; c < WIN_N - 1; c++) begin
            win_reg[gi][c] <= win_next[gi][c];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in3x3_val  <= 1'b0;
      in3x3_data <= '0;
      in3x3_sof  <= 1'b0;
      in3x3_eof  <= 1'b0;
      in3x3_sol  <= 1'b0;
      in3x3_eol  <= 1'b0;
    end else if (in_rdy) begin
      in3x3_val <= emit;
      if (emit) begin
        in3x3_data <= win_packed;
        in3x3_sof  <= first_reg;
        in3x3_eof  <= in_eof;
        in3x3_sol  <= (col_eff == COL_FIRST_WIN);
        in3x3_eol  <= in_eol;
      end else begin
        in3x3_sof  <= 1'b0;
        in3x3_eof  <= 1'b0;
        in3x3_sol  <= 1'b0;
        in3x3_eol  <= 1'b0;
      end
    end
  end

`ifdef WIN3X3_ERR_EN
  logic [ADDR_WIDTH-1:0] len_reg;
  logic                  len_valid_reg;
  logic                  err_reg;
  logic                  err_set;

  // Line lengths are compared as last-column indices against the frame's first line.
  always_comb begin
    err_set = 1'b0;
    if (proc) begin
      if ((state_reg == ACTIVE) && !in_sof && in_sol && (col_reg != '0)) begin
        err_set = 1'b1;
      end
      if (in_eol && len_valid_reg && !in_sof && (col_eff != len_reg)) begin
        err_set = 1'b1;
      end
      if (!in_eol && (col_eff == COL_MAX)) begin
        err_set = 1'b1;
      end
      if (in_eof && !in_eol) begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg       <= '0;
      len_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= err_reg | err_set;
      if (proc) begin
        if (in_eol) begin
          if (in_sof || !len_valid_reg) begin
            len_reg       <= col_eff;
            len_valid_reg <= 1'b1;
          end
        end else if (in_sof) begin
          len_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign err_flag = err_reg;
`else
  assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed self-checking bench for window_3x3_gen: frame windows, backpressure,
// pre-sof dropping, mid-frame reset, framing errors and over-long lines.
module tb_window_3x3_gen;

  localparam int DW   = 8;
  localparam int MAXW = 1024;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_val = 1'b0;
  logic            in_rdy;
  logic [DW-1:0]   in_data = '0;
  logic            in_sof = 1'b0, in_eof = 1'b0, in_sol = 1'b0, in_eol = 1'b0;
  logic            in3x3_val;
  logic            in3x3_rdy = 1'b1;
  logic [9*DW-1:0] in3x3_data;
  logic            in3x3_sof, in3x3_eof, in3x3_sol, in3x3_eol;
  logic            err_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9*DW-1:0] data;
    logic            sof, eof, sol, eol;
  } win_t;

  win_t            got[$];
  win_t            mon_w;
  int              stall_cnt = 0;
  int              stall_bad = 0;
  logic            prev_stall = 1'b0;
  logic [9*DW+3:0] prev_word = '0;
  bit              rdy_toggle = 1'b0;
  int              rdy_phase = 0;

`ifdef WIN3X3_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  window_3x3_gen #(.DATA_WIDTH(DW), .MAX_LINE_WIDTH(MAXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .in_eof     (in_eof),
    .in_sol     (in_sol),
    .in_eol     (in_eol),
    .in3x3_val  (in3x3_val),
    .in3x3_rdy  (in3x3_rdy),
    .in3x3_data (in3x3_data),
    .in3x3_sof  (in3x3_sof),
    .in3x3_eof  (in3x3_eof),
    .in3x3_sol  (in3x3_sol),
    .in3x3_eol  (in3x3_eol),
    .err_flag   (err_flag)
  );

  always #5 clk = ~clk;

  // Downstream ready: constant 1, or the repeating 1-0-0-1 pattern.
  always @(posedge clk) begin
    #1;
    if (rdy_toggle) begin
      in3x3_rdy = (rdy_phase == 0) || (rdy_phase == 3);
      rdy_phase = (rdy_phase + 1) % 4;
    end else begin
      in3x3_rdy = 1'b1;
    end
  end

  // Capture consumed windows and watch output stability under stall.
  always @(negedge clk) begin
    if (in3x3_val && in3x3_rdy) begin
      mon_w.data = in3x3_data;
      mon_w.sof  = in3x3_sof;
      mon_w.eof  = in3x3_eof;
      mon_w.sol  = in3x3_sol;
      mon_w.eol  = in3x3_eol;
      got.push_back(mon_w);
    end
    if (prev_stall && ({in3x3_data, in3x3_sof, in3x3_eof, in3x3_sol, in3x3_eol} !== prev_word))
      stall_bad++;
    if (in3x3_val && !in3x3_rdy) begin
      stall_cnt++;
      if (in_rdy !== 1'b0) stall_bad++;
    end
    prev_stall = in3x3_val && !in3x3_rdy;
    prev_word  = {in3x3_data, in3x3_sof, in3x3_eof, in3x3_sol, in3x3_eol};
  end

  function automatic logic [DW-1:0] pix(input int y, input int x);
    return DW'(16 * y + x);
  endfunction

  // Expected k-th window of a w x h frame whose pixels are pix(y,x).
  function automatic win_t exp_win(input int w, input int h, input int k);
    win_t e;
    int   y, x;
    y = 2 + k / (w - 2);
    x = 2 + k % (w - 2);
    e.data = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        e.data[(3*r+c)*DW +: DW] = pix(y - r, x - c);
    e.sof = (k == 0);
    e.sol = (x == 2);
    e.eol = (x == w - 1);
    e.eof = (x == w - 1) && (y == h - 1);
    return e;
  endfunction

  task automatic send_px(input logic [DW-1:0] d, input logic sof, input logic eof,
                         input logic sol, input logic eol);
    int guard;
    guard   = 0;
    in_val  = 1'b1;
    in_data = d;
    in_sof  = sof;
    in_eof  = eof;
    in_sol  = sol;
    in_eol  = eol;
    @(negedge clk);
    while (!in_rdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_rdy=%b required 1", in_rdy);
    end
    @(posedge clk);
    #1;
    in_val = 1'b0;
    in_sof = 1'b0;
    in_eof = 1'b0;
    in_sol = 1'b0;
    in_eol = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        send_px(pix(y, x), (y == 0) && (x == 0), (y == h - 1) && (x == w - 1),
                x == 0, x == w - 1);
  endtask

  task automatic drain();
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in3x3_val, in3x3_sof, in3x3_eof, in3x3_sol, in3x3_eol} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: val/sof/eof/sol/eol=%b required 00000",
               {in3x3_val, in3x3_sof, in3x3_eof, in3x3_sol, in3x3_eol});
    end
    checks++;
    if (in3x3_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", in3x3_data);
    end
    checks++;
    if (err_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b required 0", err_flag);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_rdy !== 1'b1 || in3x3_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: in_rdy=%b val=%b required 1 0", in_rdy, in3x3_val);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_frame();
    win_t e;
    got.delete();
    send_frame(5, 4);
    drain();
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL basic_count: got %0d windows required 6", got.size());
    end
    if (got.size() > 0) begin
      checks++;
      if (got[0].data[4*DW +: DW] !== 8'h11 || got[0].data[0 +: DW] !== 8'h22 ||
          got[0].data[8*DW +: DW] !== 8'h00) begin
        errors++;
        $display("FAIL basic_first: centre=%h w0=%h w8=%h required 11 22 00",
                 got[0].data[4*DW +: DW], got[0].data[0 +: DW], got[0].data[8*DW +: DW]);
      end
    end
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      e = exp_win(5, 4, k);
      checks++;
      if (got[k].data !== e.data || {got[k].sof, got[k].sol, got[k].eol, got[k].eof} !==
          {e.sof, e.sol, e.eol, e.eof}) begin
        errors++;
        $display("FAIL basic_win%0d: data=%h sof/sol/eol/eof=%b required data=%h markers=%b",
                 k, got[k].data, {got[k].sof, got[k].sol, got[k].eol, got[k].eof},
                 e.data, {e.sof, e.sol, e.eol, e.eof});
      end
    end
    $display("test_basic_frame: %0d windows", got.size());
  endtask

  task automatic test_backpressure();
    win_t e;
    got.delete();
    stall_cnt  = 0;
    stall_bad  = 0;
    rdy_phase  = 0;
    rdy_toggle = 1'b1;
    send_frame(5, 4);
    drain();
    rdy_toggle = 1'b0;
    drain();
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d windows required 6", got.size());
    end
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      e = exp_win(5, 4, k);
      checks++;
      if (got[k].data !== e.data || {got[k].sof, got[k].sol, got[k].eol, got[k].eof} !==
          {e.sof, e.sol, e.eol, e.eof}) begin
        errors++;
        $display("FAIL bp_win%0d: data=%h markers=%b required data=%h markers=%b",
                 k, got[k].data, {got[k].sof, got[k].sol, got[k].eol, got[k].eof},
                 e.data, {e.sof, e.sol, e.eol, e.eof});
      end
    end
    checks++;
    if (stall_cnt == 0 || stall_bad != 0) begin
      errors++;
      $display("FAIL bp_stall: stalls=%0d violations=%0d required >0 and 0", stall_cnt, stall_bad);
    end
    $display("test_backpressure: %0d windows, %0d stall cycles", got.size(), stall_cnt);
  endtask

  task automatic test_no_sof();
    win_t e;
    got.delete();
    for (int x = 0; x < 4; x++) send_px(8'hE0 + 8'(x), 1'b0, 1'b0, x == 0, x == 3);
    send_frame(4, 3);
    drain();
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL nosof_count: got %0d windows required 2", got.size());
    end
    for (int k = 0; k < 2 && k < got.size(); k++) begin
      e = exp_win(4, 3, k);
      checks++;
      if (got[k].data !== e.data || {got[k].sof, got[k].sol, got[k].eol, got[k].eof} !==
          {e.sof, e.sol, e.eol, e.eof}) begin
        errors++;
        $display("FAIL nosof_win%0d: data=%h markers=%b required data=%h markers=%b",
                 k, got[k].data, {got[k].sof, got[k].sol, got[k].eol, got[k].eof},
                 e.data, {e.sof, e.sol, e.eol, e.eof});
      end
    end
    $display("test_no_sof: %0d windows", got.size());
  endtask

  task automatic test_reset_mid();
    win_t e;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 5; x++)
        send_px(pix(y, x), (y == 0) && (x == 0), 1'b0, x == 0, x == 4);
    for (int x = 0; x < 3; x++) send_px(pix(2, x), 1'b0, 1'b0, x == 0, 1'b0);
    checks++;
    if (in3x3_val !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pending: val=%b required 1", in3x3_val);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in3x3_val !== 1'b0 || in3x3_data !== '0) begin
      errors++;
      $display("FAIL rstmid_drop: val=%b data=%h required 0 0", in3x3_val, in3x3_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
    for (int x = 0; x < 4; x++) send_px(8'hA0 + 8'(x), 1'b0, 1'b0, x == 0, x == 3);
    drain();
    checks++;
    if (got.size() != 0) begin
      errors++;
      $display("FAIL rstmid_presof: got %0d windows required 0", got.size());
    end
    send_frame(3, 3);
    drain();
    checks++;
    if (got.size() != 1) begin
      errors++;
      $display("FAIL rstmid_count: got %0d windows required 1", got.size());
    end
    if (got.size() > 0) begin
      e = exp_win(3, 3, 0);
      checks++;
      if (got[0].data !== e.data || {got[0].sof, got[0].sol, got[0].eol, got[0].eof} !== 4'b1111) begin
        errors++;
        $display("FAIL rstmid_win: data=%h markers=%b required data=%h markers=1111",
                 got[0].data, {got[0].sof, got[0].sol, got[0].eol, got[0].eof}, e.data);
      end
    end
    $display("test_reset_mid: %0d windows after restart", got.size());
  endtask

  task automatic test_err();
    got.delete();
    for (int x = 0; x < 6; x++) send_px(pix(0, x), x == 0, 1'b0, x == 0, x == 5);
    for (int x = 0; x < 4; x++) send_px(pix(1, x), 1'b0, 1'b0, x == 0, 1'b0);
    checks++;
    if (err_flag !== 1'b0) begin
      errors++;
      $display("FAIL err_before: got %b required 0", err_flag);
    end
    send_px(pix(1, 4), 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (err_flag !== ERR_EXP) begin
      errors++;
      $display("FAIL err_short_line: got %b required %b", err_flag, ERR_EXP);
    end
    send_frame(3, 3);
    drain();
    checks++;
    if (err_flag !== ERR_EXP || got.size() != 1) begin
      errors++;
      $display("FAIL err_sticky: err=%b windows=%0d required %b 1", err_flag, got.size(), ERR_EXP);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (err_flag !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b required 0", err_flag);
    end
    $display("test_err: err_flag=%b after reset", err_flag);
  endtask

  task automatic test_long_line();
    win_t e;
    got.delete();
    send_frame(1030, 3);
    drain();
    checks++;
    if (got.size() != 1028) begin
      errors++;
      $display("FAIL long_count: got %0d windows required 1028", got.size());
    end
    if (got.size() > 0) begin
      e = exp_win(1030, 3, 0);
      checks++;
      if (got[0].data !== e.data || got[0].sof !== 1'b1 || got[0].sol !== 1'b1) begin
        errors++;
        $display("FAIL long_first: data=%h sof=%b sol=%b required data=%h 1 1",
                 got[0].data, got[0].sof, got[0].sol, e.data);
      end
      checks++;
      if (got[got.size()-1].eol !== 1'b1 || got[got.size()-1].eof !== 1'b1) begin
        errors++;
        $display("FAIL long_last: eol=%b eof=%b required 1 1",
                 got[got.size()-1].eol, got[got.size()-1].eof);
      end
    end
    checks++;
    if (err_flag !== ERR_EXP) begin
      errors++;
      $display("FAIL long_err: got %b required %b", err_flag, ERR_EXP);
    end
    got.delete();
    send_frame(3, 3);
    drain();
    e = exp_win(3, 3, 0);
    checks++;
    if (got.size() != 1 || (got.size() > 0 && got[0].data !== e.data)) begin
      errors++;
      $display("FAIL long_recover: windows=%0d required 1 with data %h", got.size(), e.data);
    end
    $display("test_long_line: recovered with %0d windows", got.size());
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_no_sof();
    test_reset_mid();
    test_err();
    test_long_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
